// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_ctrl
//  Description : FF46-style OAM DMA initiator. A CPU write to REG_ADDR
//                latches a source page; the block then masters the shared
//                bus, copying LEN bytes from {page,00h} upward to DEST_BASE.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   system clock, rising edge
//    rst        in   1   asynchronous reset, active low
//    cpu_addr   in  16   CPU bus address
//    cpu_we     in   1   CPU write strobe
//    cpu_oe     in   1   CPU read enable
//    cpu_din    in   8   CPU write data
//    cpu_dout   out  8   page register readback, high-Z when not selected
//    dma_addr   out 16   bus address while mastering
//    dma_en     out  1   responder enable
//    dma_oe     out  1   responder read enable
//    dma_we     out  1   responder write strobe
//    dma_rdata  in   8   responder read data (valid one cycle after address)
//    dma_wdata  out  8   responder write data
//    busy       out  1   bus request to the arbiter
//    done       out  1   one-cycle pulse after the final byte is written
// ============================================================================
module oam_dma_ctrl #(
  parameter int unsigned LEN       = 160,
  parameter logic [15:0] DEST_BASE = 16'hFE00,
  parameter logic [15:0] REG_ADDR  = 16'hFF46,
  parameter int unsigned GAP       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_oe,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic [15:0] dma_addr,
  output logic        dma_en,
  output logic        dma_oe,
  output logic        dma_we,
  input  logic [7:0]  dma_rdata,
  output logic [7:0]  dma_wdata,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_read   = 3'd1;
  localparam logic [2:0] c_st_latch  = 3'd2;
  localparam logic [2:0] c_st_write  = 3'd3;
  localparam logic [2:0] c_st_gap    = 3'd4;
  localparam logic [2:0] c_st_finish = 3'd5;

  localparam logic [7:0] c_last_idx = 8'(LEN - 1);
  localparam bit         c_has_gap  = (GAP != 0);
  // Only meaningful when c_has_gap; the GAP state is unreachable otherwise.
  localparam logic [3:0] c_gap_last = 4'(GAP - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_data;
  logic [3:0] r_gap_cnt;

  logic       w_trigger;
  logic       w_last;
  logic [7:0] w_eff_page;

  assign w_trigger = cpu_we && (cpu_addr == REG_ADDR);
  assign w_last    = (r_idx == c_last_idx);

  // Pages E0h..FFh alias the WRAM echo region, so bit 5 is stripped.
  assign w_eff_page = (r_page >= 8'hE0) ? (r_page & 8'hDF) : r_page;

  // The stored page is the raw CPU value; only the bus source uses the mask.
  assign cpu_dout = (cpu_oe && (cpu_addr == REG_ADDR)) ? r_page : 8'hzz;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a trigger restarts the transfer from any state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   w_state_nxt = c_st_idle;
      c_st_read:   w_state_nxt = c_st_latch;
      c_st_latch:  w_state_nxt = c_st_write;
      c_st_write: begin
        if (w_last) begin
          w_state_nxt = c_st_finish;
        end else if (c_has_gap) begin
          w_state_nxt = c_st_gap;
        end else begin
          w_state_nxt = c_st_read;
        end
      end
      c_st_gap: begin
        if (r_gap_cnt == c_gap_last) begin
          w_state_nxt = c_st_read;
        end
      end
      c_st_finish: w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
    if (w_trigger) begin
      w_state_nxt = c_st_read;
    end
  end

  // Datapath: page register, byte index, read-data holding register, gap timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_page    <= 8'h00;
      r_idx     <= 8'h00;
      r_data    <= 8'h00;
      r_gap_cnt <= 4'h0;
    end else begin
      if (w_trigger) begin
        r_page <= cpu_din;
        r_idx  <= 8'h00;
      end else if ((r_state == c_st_write) && !w_last) begin
        // Holding at LEN-1 keeps LEN==256 from wrapping into the next page.
        r_idx <= r_idx + 8'd1;
      end

      if (r_state == c_st_latch) begin
        r_data <= dma_rdata;
      end

      if (r_state == c_st_gap) begin
        r_gap_cnt <= r_gap_cnt + 4'd1;
      end else begin
        r_gap_cnt <= 4'h0;
      end
    end
  end

  // Outputs are decoded from state alone, so an asynchronous reset drops
  // every strobe in the same instant.
  always_comb begin
    dma_addr  = 16'h0000;
    dma_en    = 1'b0;
    dma_oe    = 1'b0;
    dma_we    = 1'b0;
    dma_wdata = 8'h00;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      c_st_read, c_st_latch: begin
        dma_addr = {w_eff_page, r_idx};
        dma_en   = 1'b1;
        dma_oe   = 1'b1;
        busy     = 1'b1;
      end
      c_st_write: begin
        dma_addr  = DEST_BASE + {8'h00, r_idx};
        dma_en    = 1'b1;
        dma_we    = 1'b1;
        dma_wdata = r_data;
        busy      = 1'b1;
      end
      c_st_gap: begin
        busy = 1'b1;
      end
      c_st_finish: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oam_dma_ctrl
//  Description : Self-checking bench for oam_dma_ctrl. A byte-array memory
//                answers reads; every bus write, read and done pulse is logged
//                with its cycle number and compared against the transfer the
//                DMA rules predict.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_oam_dma_ctrl;

  localparam int          LEN       = 160;
  localparam logic [15:0] DEST_BASE = 16'hFE00;
  localparam logic [15:0] REG_ADDR  = 16'hFF46;
  localparam int          GAP       = 1;
  localparam int          PER       = 3 + GAP;   // cycles per byte

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_we = 1'b0;
  logic        cpu_oe = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic [15:0] dma_addr;
  logic        dma_en, dma_oe, dma_we;
  logic [7:0]  dma_rdata = 8'h00;
  logic [7:0]  dma_wdata;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];
  logic [15:0] rd_q[$];
  int          done_q[$];

  oam_dma_ctrl #(
    .LEN(LEN), .DEST_BASE(DEST_BASE), .REG_ADDR(REG_ADDR), .GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_oe(cpu_oe),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .dma_addr(dma_addr), .dma_en(dma_en), .dma_oe(dma_oe), .dma_we(dma_we),
    .dma_rdata(dma_rdata), .dma_wdata(dma_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous responder: data appears the cycle after the address.
  always @(posedge clk) begin
    if (dma_en && dma_oe) dma_rdata <= mem[dma_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (dma_en && dma_we) begin
        wr_addr_q.push_back(dma_addr);
        wr_data_q.push_back(dma_wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (dma_en && dma_oe) rd_q.push_back(dma_addr);
      if (done) begin
        done_q.push_back(cyc);
        check("busy_low_at_done", busy, 0);
      end
      check("oe_we_exclusive", dma_oe && dma_we, 0);
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_q.delete(); done_q.delete();
  endtask

  // Returns the cycle number of the first cycle after the trigger edge.
  task automatic trigger(input logic [7:0] page, output int t);
    @(negedge clk);
    cpu_addr = REG_ADDR; cpu_din = page; cpu_we = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    check("busy_after_trigger", busy, 1);
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_oe = 1'b1;
    #1 d = cpu_dout;
    cpu_oe = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int c = 0;
    while (wr_addr_q.size() < n && c < budget) begin
      @(negedge clk); #1; c++;
    end
    check("wait_writes_timeout", wr_addr_q.size() >= n, 1);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_q.size() == 0 && c < budget) begin
      @(negedge clk); #1; c++;
    end
    check("wait_done_timeout", done_q.size() != 0, 1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  // Expected transfer: byte i comes from {page masked for echo, i} and lands
  // at DEST_BASE+i; its write is in cycle 3+PER*i counting the first cycle
  // after the trigger as 1, with the two read cycles just before it.
  task automatic check_transfer(input logic [7:0] page, input int t,
                                input int wbase, input int rbase, input int n);
    logic [7:0]  eff;
    logic [15:0] src;
    logic [7:0]  ib;
    eff = (page >= 8'hE0) ? (page & 8'hDF) : page;
    for (int i = 0; i < n; i++) begin
      ib  = 8'(i);
      src = {eff, ib};
      if (wbase + i < wr_addr_q.size()) begin
        check("wr_addr", wr_addr_q[wbase+i], DEST_BASE + 16'(i));
        check("wr_data", wr_data_q[wbase+i], mem[src]);
        check("wr_cycle", wr_cyc_q[wbase+i], t + 2 + PER*i);
      end
      if (rbase + 2*i + 1 < rd_q.size()) begin
        check("rd_addr_first", rd_q[rbase+2*i], src);
        check("rd_addr_second", rd_q[rbase+2*i+1], src);
      end
    end
  endtask

  task automatic full_transfer(input logic [7:0] page, input string tag);
    int t;
    clear_logs();
    trigger(page, t);
    wait_done(LEN*PER + 100);
    check({tag, "_wr_count"}, wr_addr_q.size(), LEN);
    check({tag, "_rd_count"}, rd_q.size(), 2*LEN);
    check({tag, "_done_count"}, done_q.size(), 1);
    if (done_q.size() != 0) check({tag, "_done_cycle"}, done_q[0], t + 3 + PER*(LEN-1));
    check({tag, "_busy_end"}, busy, 0);
    check_transfer(page, t, 0, 0, LEN);
  endtask

  initial begin
    logic [7:0] d;
    int t1, t2, nw;
    logic [7:0] pg;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < LEN; i++) mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_dma_en", dma_en, 0);
    check("rst_dma_oe", dma_oe, 0);
    check("rst_dma_we", dma_we, 0);
    check("rst_dma_addr", dma_addr, 16'h0000);
    check("rst_dma_wdata", dma_wdata, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    // A 2-state simulator resolves an undriven bus to zero.
    check("rst_dout_z", $isunknown(cpu_dout) || (cpu_dout == 8'h00), 1);
    rst = 1'b1;
    cpu_read(REG_ADDR, d);
    check("rst_page_read", d, 8'h00);

    // Full transfer from C1xx, plus raw readback mid-transfer
    clear_logs();
    trigger(8'hC1, t1);
    cpu_read(REG_ADDR, d);
    check("read_page_c1", d, 8'hC1);
    wait_done(LEN*PER + 100);
    check("c1_wr_count", wr_addr_q.size(), LEN);
    check("c1_done_count", done_q.size(), 1);
    if (done_q.size() != 0) check("c1_done_cycle", done_q[0], t1 + 3 + PER*(LEN-1));
    check("c1_busy_end", busy, 0);
    check_transfer(8'hC1, t1, 0, 0, LEN);

    // Echo page F2h reads from D2xx; readback returns the raw value
    clear_logs();
    trigger(8'hF2, t1);
    cpu_read(REG_ADDR, d);
    check("read_page_f2", d, 8'hF2);
    cpu_read(16'hFF47, d);
    check("dout_z_ff47", $isunknown(d) || (d == 8'h00), 1);
    wait_done(LEN*PER + 100);
    check("f2_rd_count", rd_q.size(), 2*LEN);
    if (rd_q.size() != 0) check("f2_first_rd", rd_q[0], 16'hD200);
    if (rd_q.size() == 2*LEN) check("f2_last_rd", rd_q[2*LEN-1], 16'hD29F);
    check_transfer(8'hF2, t1, 0, 0, LEN);

    // Retrigger with C3h once 50 bytes of C1h have been written
    clear_logs();
    trigger(8'hC1, t1);
    wait_writes(50, 60*PER);
    trigger(8'hC3, t2);
    wait_done(LEN*PER + 100);
    check("rt_wr_count", wr_addr_q.size(), 50 + LEN);
    check("rt_rd_count", rd_q.size(), 2*(50 + LEN));
    check("rt_done_count", done_q.size(), 1);
    if (done_q.size() != 0) check("rt_done_cycle", done_q[0], t2 + 3 + PER*(LEN-1));
    check_transfer(8'hC1, t1, 0, 0, 50);
    check_transfer(8'hC3, t2, 50, 100, LEN);

    // Reset during the WRITE of byte 10
    clear_logs();
    trigger(8'hC1, t1);
    wait_writes(11, 20*PER);
    #1 rst = 1'b0;
    #1;
    check("abort_dma_en", dma_en, 0);
    check("abort_dma_we", dma_we, 0);
    check("abort_dma_oe", dma_oe, 0);
    check("abort_busy", busy, 0);
    nw = wr_addr_q.size();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_more_writes", wr_addr_q.size(), nw);
    check("abort_no_done", done_q.size(), 0);
    check("abort_idle_busy", busy, 0);
    cpu_read(REG_ADDR, d);
    check("abort_page_cleared", d, 8'h00);
    full_transfer(8'hC1, "post_abort");

    // Randomized pages: one ordinary, one in the echo range
    pg = 8'($urandom_range(0, 8'hDF));
    full_transfer(pg, "rand_low");
    pg = 8'($urandom_range(8'hE0, 8'hFF));
    full_transfer(pg, "rand_echo");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
